// File: rtl/wb_ram_arbiter.sv
`timescale 1ns/1ps
// Two-master Wishbone classic arbiter in front of one single-port, registered-read RAM.
// Round-robin grant; byte-select writes are emulated with a read-modify-write pass.
//
// state | meaning
// IDLE  | arbitrate; latch the winner's address/we/sel/data
// WRITE | full-word write driven onto the RAM
// READ  | address presented; RAM read data arrives next cycle
// DATA  | RAM data valid: capture read data, or write back the merged word
// ACK   | one-cycle ack to the granted master
module wb_ram_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [addr_width-1:0]   m0_adr_i,
  input  logic [data_width/8-1:0] m0_sel_i,
  input  logic [data_width-1:0]   m0_dat_i,
  output logic [data_width-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [addr_width-1:0]   m1_adr_i,
  input  logic [data_width/8-1:0] m1_sel_i,
  input  logic [data_width-1:0]   m1_dat_i,
  output logic [data_width-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic [addr_width-1:0]   ram_addr,
  output logic                    ram_we,
  output logic [data_width-1:0]   ram_dat_in,
  input  logic [data_width-1:0]   ram_dat_out
);

  localparam int sel_width = data_width / 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DATA, ACK} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [addr_width-1:0]   adr_q, adr_d;
  logic [sel_width-1:0]    sel_q, sel_d;
  logic [data_width-1:0]   dat_q, dat_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;

  logic                    req0, req1;
  logic                    pick;
  logic                    gnt_cyc;
  logic [data_width-1:0]   merged;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  // On a tie the master that did not win last time gets the bus.
  assign pick = (req0 & req1) ? ~last_grant_q : req1;
  assign gnt_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;

  always_comb begin
    merged = ram_dat_out;
    for (int b = 0; b < sel_width; b++) begin
      if (sel_q[b]) merged[b*8 +: 8] = dat_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    rdata_d      = rdata_q;
    ram_we       = 1'b0;
    ram_dat_in   = dat_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = pick ? m1_we_i  : m0_we_i;
          adr_d        = pick ? m1_adr_i : m0_adr_i;
          sel_d        = pick ? m1_sel_i : m0_sel_i;
          dat_d        = pick ? m1_dat_i : m0_dat_i;
          state_d      = (we_d && (&sel_d)) ? WRITE : READ;
        end
      end
      WRITE: begin
        // The write commits on this edge even if the master is aborting.
        ram_we  = 1'b1;
        state_d = gnt_cyc ? ACK : IDLE;
      end
      READ: begin
        state_d = gnt_cyc ? DATA : IDLE;
      end
      DATA: begin
        if (gnt_cyc) begin
          if (we_q) begin
            ram_we     = 1'b1;
            ram_dat_in = merged;
          end else begin
            rdata_d = ram_dat_out;
          end
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack0_d = (state_d == ACK) & ~gnt_d;
    ack1_d = (state_d == ACK) &  gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  assign ram_addr = adr_q;
  assign m0_ack_o = ack0_q;
  assign m1_ack_o = ack1_q;
  assign m0_dat_o = rdata_q;
  assign m1_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for wb_ram_arbiter: vector table, corner-case sequences,
// and random single-master traffic against a word-array memory model.
module tb_wb_ram_arbiter;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [7:0]  m0_adr, m1_adr;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_dat_in;
  logic [31:0] ram_dat_out;

  logic [31:0] mem [256] = '{default: 32'h0};

  int total = 0;
  int bad   = 0;

  wb_ram_arbiter #(.data_width(32), .addr_width(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dat_in(ram_dat_in),
    .ram_dat_out(ram_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM, read-first on a write edge.
  always @(posedge clk) begin
    ram_dat_out <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_dat_in;
  end

  typedef struct {
    int          m;
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          lat;
    logic [15:0] wem;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] ref_mem [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [7:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = req; m0_stb = req; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat = dat;
    end else begin
      m1_cyc = req; m1_stb = req; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat = dat;
    end
  endtask

  // Starts from IDLE just after an edge; returns cycles to ack (-1 on timeout),
  // per-cycle ram_we mask, read data at ack, and an ack-exclusivity violation flag.
  task automatic do_txn(input int m, input logic we, input logic [7:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output int lat, output logic [31:0] rd,
                        output logic [15:0] wem, output bit bad_oh);
    lat = -1; rd = 32'h0; wem = 16'h0; bad_oh = 1'b0;
    drive(m, 1'b1, we, adr, sel, dat);
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (ram_we) wem[n] = 1'b1;
      if ((m == 0 && m1_ack_o) || (m == 1 && m0_ack_o)) bad_oh = 1'b1;
      if (m == 0 && m0_ack_o) begin lat = n; rd = m0_dat_o; end
      if (m == 1 && m1_ack_o) begin lat = n; rd = m1_dat_o; end
    end
    drive(m, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = sel[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [15:0] wem;
    bit          oh;
    int          ack_m [4];
    int          ack_n [4];
    int          seen;
    bit          both, m0_seen, we_seen, ack_seen;
    int          m1_n, m0_n;
    logic [31:0] m0_rd, m1_rd;

    tbl[0]  = '{0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 2, 16'h0002, 32'h0};
    tbl[1]  = '{1, 1'b0, 8'h10, 4'hF, 32'h0,        3, 16'h0000, 32'hDEADBEEF};
    tbl[2]  = '{0, 1'b1, 8'h10, 4'h3, 32'h00001234, 3, 16'h0004, 32'h0};
    tbl[3]  = '{0, 1'b0, 8'h10, 4'h0, 32'h0,        3, 16'h0000, 32'hDEAD1234};
    tbl[4]  = '{1, 1'b1, 8'h10, 4'h0, 32'hFFFFFFFF, 3, 16'h0004, 32'h0};
    tbl[5]  = '{1, 1'b0, 8'h10, 4'h0, 32'h0,        3, 16'h0000, 32'hDEAD1234};
    tbl[6]  = '{1, 1'b1, 8'h10, 4'hC, 32'hABCD0000, 3, 16'h0004, 32'h0};
    tbl[7]  = '{0, 1'b0, 8'h10, 4'h0, 32'h0,        3, 16'h0000, 32'hABCD1234};
    tbl[8]  = '{0, 1'b1, 8'hFF, 4'hF, 32'h12345678, 2, 16'h0002, 32'h0};
    tbl[9]  = '{1, 1'b0, 8'hFF, 4'h0, 32'h0,        3, 16'h0000, 32'h12345678};
    tbl[10] = '{0, 1'b0, 8'h00, 4'h0, 32'h0,        3, 16'h0000, 32'h00000000};
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    #3;
    chk("reset_ack0", {31'h0, m0_ack_o}, 32'h0);
    chk("reset_ack1", {31'h0, m1_ack_o}, 32'h0);
    chk("reset_ram_we", {31'h0, ram_we}, 32'h0);
    chk("reset_ram_addr", {24'h0, ram_addr}, 32'h0);
    chk("reset_dat_o", m0_dat_o | m1_dat_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_txn(tbl[i].m, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, lat, rd, wem, oh);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_ram_we_cycles", i), {16'h0, wem}, {16'h0, tbl[i].wem});
      chk($sformatf("vec%0d_other_ack", i), {31'h0, oh}, 32'h0);
      if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
    end

    // Continuous contention from reset: strict alternation, one full write per 3 cycles.
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 8'h01, 4'hF, 32'h11111111);
    drive(1, 1'b1, 1'b1, 8'h02, 4'hF, 32'h22222222);
    #2 rst = 1'b0;
    seen = 0; both = 1'b0;
    for (int i = 0; i < 4; i++) begin ack_m[i] = -1; ack_n[i] = -1; end
    for (int n = 1; n <= 30 && seen < 4; n++) begin
      @(posedge clk); #1;
      if (m0_ack_o && m1_ack_o) both = 1'b1;
      if (m0_ack_o || m1_ack_o) begin
        ack_m[seen] = m1_ack_o ? 1 : 0;
        ack_n[seen] = n;
        seen++;
      end
    end
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    chk("contend_ack_count", 32'(seen), 32'd4);
    chk("contend_both_acks", {31'h0, both}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend_ack%0d_master", i), 32'(ack_m[i]), 32'(i % 2));
      chk($sformatf("contend_ack%0d_cycle", i), 32'(ack_n[i]), 32'(2 + 3 * i));
    end
    chk("contend_mem01", mem[8'h01], 32'h11111111);
    chk("contend_mem02", mem[8'h02], 32'h22222222);

    // m0 wins the tie, then abandons its read in READ; m1 is served next.
    drive(0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h02, 4'h0, 32'h0);
    m1_n = -1; m0_seen = 1'b0; we_seen = 1'b0; m1_rd = 32'h0;
    for (int n = 1; n <= 12 && m1_n < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk("abort_m0_granted_addr", {24'h0, ram_addr}, 32'h10);
        drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
      end
      if (m0_ack_o) m0_seen = 1'b1;
      if (ram_we) we_seen = 1'b1;
      if (m1_ack_o) begin m1_n = n; m1_rd = m1_dat_o; end
    end
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    chk("abort_no_m0_ack", {31'h0, m0_seen}, 32'h0);
    chk("abort_no_ram_we", {31'h0, we_seen}, 32'h0);
    chk("abort_m1_ack_cycle", 32'(m1_n), 32'd5);
    chk("abort_m1_rdata", m1_rd, 32'h22222222);

    // Reset hits the DATA cycle of a partial write.
    drive(0, 1'b1, 1'b1, 8'h10, 4'h1, 32'h000000EE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstdata_we_before", {31'h0, ram_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstdata_we_dropped", {31'h0, ram_we}, 32'h0);
    chk("rstdata_ack", {30'h0, m0_ack_o, m1_ack_o}, 32'h0);
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    #1 rst = 1'b0;
    ack_seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (m0_ack_o || m1_ack_o) ack_seen = 1'b1;
    end
    chk("rstdata_no_late_ack", {31'h0, ack_seen}, 32'h0);
    chk("rstdata_mem_unchanged", mem[8'h10], 32'hABCD1234);

    drive(0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 8'hFF, 4'h0, 32'h0);
    m0_n = -1; m1_n = -1; m0_rd = 32'h0; m1_rd = 32'h0;
    for (int n = 1; n <= 16 && m1_n < 0; n++) begin
      @(posedge clk); #1;
      if (m0_ack_o) begin
        m0_n = n; m0_rd = m0_dat_o;
        drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
      end
      if (m1_ack_o) begin m1_n = n; m1_rd = m1_dat_o; end
    end
    drive(0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    chk("posttie_m0_first", 32'(m0_n), 32'd3);
    chk("posttie_m0_rdata", m0_rd, 32'hABCD1234);
    chk("posttie_m1_second", 32'(m1_n), 32'd7);
    chk("posttie_m1_rdata", m1_rd, 32'h12345678);

    // Random traffic in a private address window against the memory model.
    for (int i = 0; i < 40; i++) begin
      int          m;
      logic        we;
      logic [2:0]  off;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          exp_lat;
      logic [15:0] exp_wem;
      m   = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      off = 3'($urandom_range(0, 7));
      sel = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      dat = $urandom;
      exp_lat = (we && sel == 4'hF) ? 2 : 3;
      exp_wem = !we ? 16'h0 : ((sel == 4'hF) ? 16'h0002 : 16'h0004);
      do_txn(m, we, 8'h40 + {5'h0, off}, sel, dat, lat, rd, wem, oh);
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("rand%0d_ram_we_cycles", i), {16'h0, wem}, {16'h0, exp_wem});
      chk($sformatf("rand%0d_other_ack", i), {31'h0, oh}, 32'h0);
      if (we) ref_mem[off] = merge(ref_mem[off], dat, sel);
      else    chk($sformatf("rand%0d_rdata", i), rd, ref_mem[off]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
